opc8_mem_arbiter: RTL

- Shares one synchronous 24-bit-word memory port between the opc8 CPU and a single DMA requester.
- Inserts a configurable number of memory wait states.
- Stalls the CPU through its clken input until the CPU's access completes.
- Sits between the CPU bus (address/dout/din/rnw/vpa/vda) and the memory/peripheral fabric.

---
 rtl/opc8_pkg.sv | 17 +
 rtl/opc8_wait_timer.sv | 29 ++
 rtl/opc8_mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/opc8_pkg.sv
// Shared types and widths for the opc8 memory arbiter slice.
package opc8_pkg;

    localparam int WORD_W = 24;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_CPU = 2'd1,
        ARB_BUSY_DMA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/opc8_wait_timer.sv
// Loadable down-counter that times the wait states of one memory access.
module opc8_wait_timer #(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic reset_b,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(LOAD_I);
        end else if (en && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/opc8_mem_arbiter.sv
// Shares one memory port between the opc8 CPU and a DMA requester, with
// configurable wait states and a bounded DMA burst while the CPU waits.
module opc8_mem_arbiter
    import opc8_pkg::*;
#(
    parameter int WAIT_STATES   = 0,
    parameter int MAX_DMA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [WORD_W-1:0] cpu_address,
    input  logic [WORD_W-1:0] cpu_dout,
    input  logic              cpu_rnw,
    input  logic              cpu_vpa,
    input  logic              cpu_vda,
    output logic [WORD_W-1:0] cpu_din,
    output logic              cpu_clken,
    input  logic              dma_req,
    input  logic [WORD_W-1:0] dma_address,
    input  logic [WORD_W-1:0] dma_wdata,
    input  logic              dma_rnw,
    output logic              dma_ack,
    output logic [WORD_W-1:0] dma_rdata,
    output logic              mem_ce,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_rnw,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam bit       MULTI   = (WAIT_STATES > 0);
    localparam logic [7:0] MAX_CNT = 8'(MAX_DMA_BURST);

    arb_state_t        state;
    owner_t            owner;
    logic              cpu_req, dma_win, cpu_win, start, last;
    logic              cpu_done, dma_done, timer_done;
    logic [WORD_W-1:0] own_address, own_wdata;
    logic              own_rnw;
    logic [7:0]        dma_cnt;

    opc8_wait_timer #(.WAIT_STATES(WAIT_STATES)) u_timer (
        .clk     (clk),
        .reset_b (reset_b),
        .load    (start && MULTI),
        .en      (state != ARB_IDLE),
        .done    (timer_done)
    );

    // Arbitration only happens in IDLE; a started access owns memory until its last cycle.
    always_comb begin
        cpu_req  = cpu_vpa | cpu_vda;
        dma_win  = 1'b0;
        cpu_win  = 1'b0;
        if (state == ARB_IDLE) begin
            dma_win = dma_req && (!cpu_req || dma_cnt < MAX_CNT);
            cpu_win = !dma_win && cpu_req;
        end
        start    = dma_win | cpu_win;
        last     = (state == ARB_IDLE) ? !MULTI : timer_done;
        owner    = (state == ARB_BUSY_DMA || dma_win) ? OWN_DMA : OWN_CPU;
        cpu_done = last && (state == ARB_BUSY_CPU || cpu_win);
        dma_done = reset_b && last && (state == ARB_BUSY_DMA || dma_win);
    end

    always_comb begin
        mem_address = cpu_address;
        mem_wdata   = cpu_dout;
        mem_rnw     = cpu_rnw;
        if (state != ARB_IDLE) begin
            mem_address = own_address;
            mem_wdata   = own_wdata;
            mem_rnw     = own_rnw;
        end else if (owner == OWN_DMA) begin
            mem_address = dma_address;
            mem_wdata   = dma_wdata;
            mem_rnw     = dma_rnw;
        end
    end

    // Reset forces clken high so the CPU's clken-gated reset synchroniser keeps running.
    assign mem_ce    = reset_b && (state != ARB_IDLE || start);
    assign cpu_clken = !reset_b || !cpu_req || cpu_done;
    assign dma_ack   = dma_done;
    assign dma_rdata = mem_rdata;
    assign cpu_din   = mem_rdata;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= ARB_IDLE;
            own_address <= '0;
            own_wdata   <= '0;
            own_rnw     <= 1'b1;
            dma_cnt     <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (MULTI && start) begin
                        state       <= (owner == OWN_DMA) ? ARB_BUSY_DMA : ARB_BUSY_CPU;
                        own_address <= mem_address;
                        own_wdata   <= mem_wdata;
                        own_rnw     <= mem_rnw;
                    end
                end
                ARB_BUSY_CPU, ARB_BUSY_DMA: begin
                    if (timer_done) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase

            if (cpu_done) begin
                dma_cnt <= '0;
            end else if (dma_done) begin
                if (!cpu_req)              dma_cnt <= '0;
                else if (dma_cnt < MAX_CNT) dma_cnt <= dma_cnt + 8'd1;
            end
        end
    end

endmodule
